// File: rtl/cir_peak_detect_pkg.sv
// Shared widths, FSM states and result field layout for the CIR peak detector.
// Imported by the interfaces, the |x|^2 pipeline and the top level.
package cir_pkg;

    localparam int SAMPLE_WIDTH = 64;
    localparam int RESULT_WIDTH = 64;
    localparam int MAG_BITS     = 16;
    localparam int INDEX_WIDTH  = 16;
    localparam int POWER_WIDTH  = 2 * MAG_BITS;
    localparam int STRB_WIDTH   = RESULT_WIDTH / 8;

    localparam int LEN_LSB   = 0;
    localparam int INDEX_LSB = LEN_LSB + INDEX_WIDTH;
    localparam int POWER_LSB = INDEX_LSB + INDEX_WIDTH;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        OUTPUT
    } state_t;

    function automatic logic [RESULT_WIDTH-1:0] pack_result(
        input logic [POWER_WIDTH-1:0] power,
        input logic [INDEX_WIDTH-1:0] index,
        input logic [INDEX_WIDTH-1:0] len
    );
        logic [RESULT_WIDTH-1:0] r;
        r = '0;
        r[POWER_LSB +: POWER_WIDTH] = power;
        r[INDEX_LSB +: INDEX_WIDTH] = index;
        r[LEN_LSB   +: INDEX_WIDTH] = len;
        return r;
    endfunction

endpackage

// File: rtl/cir_peak_detect_if.sv
// AXI-Stream style bundles: complex sample input stream and one-beat result stream.
// master drives the payload, slave drives TREADY.
interface cir_peak_detect_s_if;
    import cir_pkg::*;

    logic                    TVALID;
    logic                    TREADY;
    logic [SAMPLE_WIDTH-1:0] TDATA;
    logic                    TLAST;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

interface cir_peak_detect_m_if;
    import cir_pkg::*;

    logic                    TVALID;
    logic                    TREADY;
    logic [RESULT_WIDTH-1:0] TDATA;
    logic [STRB_WIDTH-1:0]   TSTRB;
    logic                    TLAST;

    modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/cir_peak_detect_cplx_mag_sq.sv
// Three-stage |x|^2 pipeline on the top MAG_BITS of each component, carrying a
// valid/last/index side channel alongside the data.
module cplx_mag_sq
    import cir_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [INDEX_WIDTH-1:0]        in_index,
    input  logic signed [MAG_BITS-1:0]    in_re,
    input  logic signed [MAG_BITS-1:0]    in_im,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [INDEX_WIDTH-1:0]        out_index,
    output logic [POWER_WIDTH-1:0]        out_power
);

    logic signed [MAG_BITS-1:0]    re_s;
    logic signed [MAG_BITS-1:0]    im_s;
    logic                          p1_valid;
    logic                          p1_last;
    logic [INDEX_WIDTH-1:0]        p1_index;

    logic signed [POWER_WIDTH-1:0] re_prod;
    logic signed [POWER_WIDTH-1:0] im_prod;
    logic [POWER_WIDTH-2:0]        re_sq;
    logic [POWER_WIDTH-2:0]        im_sq;
    logic                          p2_valid;
    logic                          p2_last;
    logic [INDEX_WIDTH-1:0]        p2_index;
    logic                          unused_prod_msb;

    // A square of a 16-bit signed value is at most 2^30, so the product sign bit is always 0.
    assign re_prod = POWER_WIDTH'(re_s) * POWER_WIDTH'(re_s);
    assign im_prod = POWER_WIDTH'(im_s) * POWER_WIDTH'(im_s);
    assign unused_prod_msb = re_prod[POWER_WIDTH-1] ^ im_prod[POWER_WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_s      <= '0;
            im_s      <= '0;
            p1_valid  <= 1'b0;
            p1_last   <= 1'b0;
            p1_index  <= '0;
            re_sq     <= '0;
            im_sq     <= '0;
            p2_valid  <= 1'b0;
            p2_last   <= 1'b0;
            p2_index  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_power <= '0;
        end else begin
            re_s      <= in_re;
            im_s      <= in_im;
            p1_valid  <= in_valid;
            p1_last   <= in_valid && in_last;
            p1_index  <= in_index;

            re_sq     <= re_prod[POWER_WIDTH-2:0];
            im_sq     <= im_prod[POWER_WIDTH-2:0];
            p2_valid  <= p1_valid;
            p2_last   <= p1_last;
            p2_index  <= p1_index;

            out_power <= {1'b0, re_sq} + {1'b0, im_sq};
            out_valid <= p2_valid;
            out_last  <= p2_last;
            out_index <= p2_index;
        end
    end

endmodule

// File: rtl/cir_peak_detect.sv
// Channel-impulse-response peak detector: tracks the strongest |x|^2 sample of each
// TLAST-delimited frame and reports {peak_power, peak_index, frame_len} once per frame.
module cir_peak_detect
    import cir_pkg::*;
(
    input  logic                AXIS_ACLK,
    input  logic                AXIS_ARESET,
    cir_peak_detect_s_if.slave  S_AXIS,
    cir_peak_detect_m_if.master M_AXIS
);

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   result_taken;
    logic [INDEX_WIDTH-1:0] count;

    logic                   p3_valid;
    logic                   p3_last;
    logic [INDEX_WIDTH-1:0] p3_index;
    logic [POWER_WIDTH-1:0] p3_power;

    logic [POWER_WIDTH-1:0] peak_power;
    logic [INDEX_WIDTH-1:0] peak_index;
    logic                   have_peak;
    logic                   unused_bits;

    assign accept       = S_AXIS.TVALID && S_AXIS.TREADY;
    assign result_taken = (state == OUTPUT) && M_AXIS.TREADY;
    assign unused_bits  = ^{S_AXIS.TDATA[SAMPLE_WIDTH-MAG_BITS-1:SAMPLE_WIDTH/2],
                            S_AXIS.TDATA[SAMPLE_WIDTH/2-MAG_BITS-1:0]};

    cplx_mag_sq u_mag_sq (
        .clk       (AXIS_ACLK),
        .rst       (AXIS_ARESET),
        .in_valid  (accept),
        .in_last   (S_AXIS.TLAST),
        .in_index  (count),
        .in_re     (S_AXIS.TDATA[SAMPLE_WIDTH-1 -: MAG_BITS]),
        .in_im     (S_AXIS.TDATA[SAMPLE_WIDTH/2-1 -: MAG_BITS]),
        .out_valid (p3_valid),
        .out_last  (p3_last),
        .out_index (p3_index),
        .out_power (p3_power)
    );

    // The count doubles as the next sample's index; both stick at all-ones on long frames.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            count <= '0;
        end else if (result_taken) begin
            count <= '0;
        end else if (accept && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            peak_power <= '0;
            peak_index <= '0;
            have_peak  <= 1'b0;
        end else if (result_taken) begin
            peak_power <= '0;
            peak_index <= '0;
            have_peak  <= 1'b0;
        end else if (p3_valid && (!have_peak || (p3_power > peak_power))) begin
            peak_power <= p3_power;
            peak_index <= p3_index;
            have_peak  <= 1'b1;
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && S_AXIS.TLAST) state_next = DRAIN;
            DRAIN:   if (p3_valid && p3_last)    state_next = OUTPUT;
            OUTPUT:  if (M_AXIS.TREADY)          state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Input is refused while reset is held even though the state already reads ACCUM.
    always_comb begin
        S_AXIS.TREADY = (state == ACCUM) && !AXIS_ARESET;
        M_AXIS.TVALID = (state == OUTPUT);
        M_AXIS.TLAST  = (state == OUTPUT);
        M_AXIS.TSTRB  = '1;
        M_AXIS.TDATA  = '0;
        if (state == OUTPUT) begin
            M_AXIS.TDATA = pack_result(peak_power, peak_index, count);
        end
    end

endmodule

// File: tb/tb_cir_peak_detect.sv
// Self-checking bench for cir_peak_detect: directed frame table, backpressure, bubbles,
// reset cases, then random frames against a plain-arithmetic per-frame model.
module tb_cir_peak_detect;
    import cir_pkg::*;

    typedef struct {
        string            name;
        int               n;
        logic [3:0][15:0] re;
        logic [3:0][15:0] im;
        logic [63:0]      exp;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [7:0]  strb;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    vectors = 0;
    int    miscompares = 0;
    bit    ready_random = 1'b0;
    bit    ready_force = 1'b1;
    beat_t got_q[$];
    vec_t  tbl[3];

    cir_peak_detect_s_if s_axis ();
    cir_peak_detect_m_if m_axis ();

    cir_peak_detect dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESET (rst),
        .S_AXIS      (s_axis),
        .M_AXIS      (m_axis)
    );

    always #5 clk = ~clk;

    initial begin
        m_axis.TREADY = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_axis.TREADY = ready_random ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Payload is captured half a cycle before the handshake edge it will complete on.
    always @(negedge clk) begin
        if (!rst && m_axis.TVALID && m_axis.TREADY)
            got_q.push_back({m_axis.TDATA, m_axis.TLAST, m_axis.TSTRB});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t make_vec(input string name, input int n,
                                      input logic [15:0] r0, i0, r1, i1, r2, i2, r3, i3,
                                      input logic [63:0] exp);
        vec_t v;
        v.name = name;
        v.n = n;
        v.re[0] = r0; v.im[0] = i0;
        v.re[1] = r1; v.im[1] = i1;
        v.re[2] = r2; v.im[2] = i2;
        v.re[3] = r3; v.im[3] = i3;
        v.exp = exp;
        return v;
    endfunction

    // Reference: power = re^2 + im^2 on the top 16 bits, first strict maximum wins.
    function automatic logic [63:0] model_frame(input logic [31:0] re[$], input logic [31:0] im[$]);
        longint best = -1;
        int     best_i = 0;
        int     len;
        foreach (re[i]) begin
            longint a = longint'($signed(re[i][31:16]));
            longint b = longint'($signed(im[i][31:16]));
            longint p = a * a + b * b;
            if (p > best) begin
                best = p;
                best_i = i;
            end
        end
        len = (re.size() > 65535) ? 65535 : re.size();
        if (best_i > 65535) best_i = 65535;
        return {best[31:0], 16'(best_i), 16'(len)};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] re, input logic [31:0] im, input logic last);
        int guard = 0;
        s_axis.TVALID = 1'b1;
        s_axis.TDATA  = {re, im};
        s_axis.TLAST  = last;
        while (!s_axis.TREADY && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("accept_ready", 64'(s_axis.TREADY), 64'd1);
        @(posedge clk); #1;
        s_axis.TVALID = 1'b0;
        s_axis.TLAST  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] re[$], input logic [31:0] im[$],
                                  input int gap_lo, input int gap_hi, input bit check_latency);
        for (int i = 0; i < re.size(); i++) begin
            push_beat(re[i], im[i], i == re.size() - 1);
            if (i != re.size() - 1)
                repeat ($urandom_range(gap_lo, gap_hi)) begin @(posedge clk); #1; end
        end
        if (check_latency) begin
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk); #1;
                check_output($sformatf("tvalid_at_t+%0d", c), 64'(m_axis.TVALID), 64'(c == 3));
            end
        end
    endtask

    task automatic wait_result(input string name, input logic [63:0] exp, output logic [63:0] data);
        int    guard = 0;
        beat_t g;
        data = '0;
        while (got_q.size() == 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output({name, "_present"}, 64'(got_q.size() != 0), 64'd1);
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            data = g.data;
            check_output(name, g.data, exp);
            check_output({name, "_tlast"}, 64'(g.last), 64'd1);
            check_output({name, "_tstrb"}, 64'(g.strb), 64'hFF);
        end
    endtask

    task automatic wait_tvalid(input string name);
        int guard = 0;
        while (!m_axis.TVALID && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output(name, 64'(m_axis.TVALID), 64'd1);
    endtask

    task automatic vec_to_queues(input vec_t v, output logic [31:0] re[$], output logic [31:0] im[$]);
        re = {};
        im = {};
        for (int i = 0; i < v.n; i++) begin
            re.push_back({v.re[i], 16'($urandom)});
            im.push_back({v.im[i], 16'($urandom)});
        end
    endtask

    function automatic logic [15:0] rand_comp();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 6)) - 16'd3;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] re_q[$];
        logic [31:0] im_q[$];
        logic [63:0] data;
        logic [63:0] exp;

        tbl[0] = make_vec("basic", 4, 16'sd1, 16'sd0, 16'sd0, 16'sd3, -16'sd2, -16'sd2, 16'sd0, 16'sd1,
                          64'h00000009_0001_0004);
        tbl[1] = make_vec("tie", 3, 16'sd2, 16'sd0, 16'sd0, -16'sd2, 16'sd1, 16'sd0, 16'sd0, 16'sd0,
                          64'h00000004_0000_0003);
        tbl[2] = make_vec("extreme", 1, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                          64'h80000000_0000_0001);

        s_axis.TVALID = 1'b0;
        s_axis.TDATA  = '0;
        s_axis.TLAST  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_s_tready", 64'(s_axis.TREADY), 64'd0);
        check_output("reset_m_tvalid", 64'(m_axis.TVALID), 64'd0);
        check_output("reset_m_tdata", m_axis.TDATA, 64'd0);
        rst = 1'b0;
        #1;
        check_output("release_s_tready", 64'(s_axis.TREADY), 64'd1);
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            vec_to_queues(tbl[k], re_q, im_q);
            apply_stimulus(re_q, im_q, 0, 0, 1'b1);
            wait_result(tbl[k].name, tbl[k].exp, data);
        end

        $display("[TB] backpressure");
        ready_force = 1'b0;
        @(posedge clk); #1;
        vec_to_queues(tbl[0], re_q, im_q);
        apply_stimulus(re_q, im_q, 0, 0, 1'b0);
        wait_tvalid("bp_tvalid_rise");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_output("bp_tvalid", 64'(m_axis.TVALID), 64'd1);
            check_output("bp_tdata", m_axis.TDATA, tbl[0].exp);
            check_output("bp_s_tready", 64'(s_axis.TREADY), 64'd0);
        end
        ready_force = 1'b1;
        wait_result("bp_result", tbl[0].exp, data);
        check_output("bp_s_tready_after", 64'(s_axis.TREADY), 64'd1);

        $display("[TB] bubbles, back-to-back");
        for (int f = 0; f < 2; f++) begin
            re_q = {};
            im_q = {};
            for (int i = 0; i < 3; i++) begin
                re_q.push_back({rand_comp(), 16'($urandom)});
                im_q.push_back({rand_comp(), 16'($urandom)});
            end
            exp = model_frame(re_q, im_q);
            apply_stimulus(re_q, im_q, 1, 1, 1'b0);
            wait_result($sformatf("bubble_frame%0d", f), exp, data);
            check_output($sformatf("bubble_len%0d", f), 64'(data[15:0]), 64'd3);
        end

        $display("[TB] reset mid-frame");
        push_beat({16'sd7, 16'h0}, {16'sd7, 16'h0}, 1'b0);
        push_beat({16'sd9, 16'h0}, {16'sd1, 16'h0}, 1'b0);
        rst = 1'b1;
        #1;
        check_output("midframe_rst_m_tvalid", 64'(m_axis.TVALID), 64'd0);
        check_output("midframe_rst_m_tdata", m_axis.TDATA, 64'd0);
        check_output("midframe_rst_s_tready", 64'(s_axis.TREADY), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset mid-output");
        ready_force = 1'b0;
        @(posedge clk); #1;
        push_beat({16'sd100, 16'h0}, {16'sd0, 16'h0}, 1'b1);
        wait_tvalid("midout_tvalid_rise");
        rst = 1'b1;
        #1;
        check_output("midout_rst_m_tvalid", 64'(m_axis.TVALID), 64'd0);
        check_output("midout_rst_m_tdata", m_axis.TDATA, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_force = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_output("no_beat_after_reset", 64'(got_q.size()), 64'd0);

        re_q = {{16'sd0, 16'($urandom)}};
        im_q = {{16'sd5, 16'($urandom)}};
        apply_stimulus(re_q, im_q, 0, 0, 1'b1);
        wait_result("post_reset_frame", 64'h00000019_0000_0001, data);

        $display("[TB] random frames");
        ready_random = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n = $urandom_range(1, 8);
            re_q = {};
            im_q = {};
            for (int i = 0; i < n; i++) begin
                re_q.push_back({rand_comp(), 16'($urandom)});
                im_q.push_back({rand_comp(), 16'($urandom)});
            end
            exp = model_frame(re_q, im_q);
            apply_stimulus(re_q, im_q, 0, 2, 1'b0);
            wait_result($sformatf("random_frame%0d", f), exp, data);
        end
        ready_random = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("no_extra_beats", 64'(got_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cir_peak_detect.md
Name: cir_peak_detect

Overview:
- Downstream consumer of the complex combine stage's 64-bit complex output stream (real in [63:32], imag in [31:0], both signed).
- Computes instantaneous power |x|^2 per sample over a frame delimited by TLAST.
- Reports one result beat per frame: peak power, peak sample index and frame length. Together these give the channel-impulse-response peak report for the sounder.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 64, input sample width; real = upper half, imag = lower half.
- C_M_AXIS_TDATA_WIDTH, 64, result width.
- C_MAG_BITS, 16, MSBs kept per component before squaring (component[31:16]).
- C_INDEX_WIDTH, 16, width of the sample counter and the peak index.

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  reset, asynchronous, active-high.
- S_AXIS_TVALID  in  1  input sample valid.
- S_AXIS_TREADY  out  1  block accepts a sample.
- S_AXIS_TDATA  in  64  {real[31:0], imag[31:0]}.
- S_AXIS_TLAST  in  1  last sample of frame.
- M_AXIS_TVALID  out  1  result valid.
- M_AXIS_TREADY  in  1  downstream accepts the result.
- M_AXIS_TDATA  out  64  {peak_power[31:0], peak_index[15:0], frame_len[15:0]}.
- M_AXIS_TSTRB  out  8  constant all ones.
- M_AXIS_TLAST  out  1  equals M_AXIS_TVALID (one-beat packet).

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately.
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0 while reset is asserted.
  - FSM enters ACCUM; S_AXIS_TREADY goes to 1 combinationally once reset releases.
- Accept: a sample is accepted when S_AXIS_TVALID && S_AXIS_TREADY. S_AXIS_TREADY = (state==ACCUM).
- Pipeline, in sub-module cplx_mag_sq:
  - P1 registers re_s=real[31:16] and im_s=imag[31:16] (signed 16b), plus valid, last, index.
  - P2 registers re_s^2 and im_s^2 (unsigned 31b each).
  - P3 sums them to a 32-bit unsigned power; no overflow is possible, max 2^31 at (-32768,-32768).
- Peak update at P3:
  - First sample of a frame loads peak unconditionally.
  - Later samples replace the peak only if power > peak (strict), so on ties the earliest index wins.
- Sample counter: counts accepted beats in a frame, 0-based index. Saturates at 0xFFFF, and the index saturates with it.
  - frame_len reported = accepted beats, saturating at 0xFFFF.
- FSM:
  - ACCUM: on accepting a TLAST beat -> DRAIN.
  - DRAIN: S_AXIS_TREADY=0; waits until the TLAST beat leaves P3 -> OUTPUT.
  - OUTPUT: M_AXIS_TVALID=1 and TDATA held stable. On M_AXIS_TREADY=1 -> ACCUM; peak, index and counter clear on the same edge.
- Latency: TLAST beat accepted at edge t -> M_AXIS_TVALID high after edge t+3. Minimum frame period = frame_len + 4 cycles when M_AXIS_TREADY=1.
- Gaps: TVALID bubbles inside a frame are allowed; the pipeline advances every cycle with valid bits and bubbles do not count.
- Single-beat frame: legal. Its sample is the peak, index 0, len 1.
- Backpressure: M_AXIS_TREADY held low keeps the block in OUTPUT indefinitely, with S_AXIS_TREADY=0 and no data loss.
- Reset mid-frame or mid-OUTPUT: the partial frame and any pending result are discarded; no result beat is emitted.

Decomposition:
- Package cir_pkg holds:
  - the width constants (sample, mag, index, power = 2*C_MAG_BITS);
  - the FSM state enum {ACCUM, DRAIN, OUTPUT};
  - the M_AXIS_TDATA field offsets.
- Sub-module cplx_mag_sq: 3-stage pipelined |x|^2 with a valid/last/index side-channel, sharing clock and reset.

Test Plan:
- Basic frame: samples (re_s,im_s) = (1,0), (0,3), (-2,-2), (0,1), TLAST on the 4th, M_AXIS_TREADY=1 -> one beat with M_AXIS_TDATA=0x00000009_0001_0004, TVALID exactly 3 cycles after the TLAST accept.
- Tie: powers 4, 4, 1 from (2,0), (0,-2), (1,0) -> TDATA=0x00000004_0000_0003.
- Extreme value: single-beat frame with real=imag=0x80000000 -> TDATA=0x80000000_0000_0001.
- Backpressure: after the basic frame, hold M_AXIS_TREADY=0 for 10 cycles -> TVALID stays 1, TDATA unchanged, S_AXIS_TREADY=0; release -> handshake, then S_AXIS_TREADY=1 on the next cycle.
- Bubbles and back-to-back frames: alternate TVALID 1/0 across two 3-sample frames -> two correct results, frame_len=3 each, bubbles not counted.
- Reset mid-frame: assert AXIS_ARESET after 2 beats -> outputs clear immediately. A new 1-sample frame (0,5) after release -> TDATA=0x00000019_0000_0001.
